// File: rtl/instr_mem_ctrl_if.sv
// Fetch/response and program-load bus for instr_mem_ctrl.
// master: the fetch/load agent side; slave: the instruction memory controller.
interface instr_mem_ctrl_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) ();
   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_ready;
   logic              ld_en;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_err;
   logic              init_done;

   modport master (
      output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
      input  req_ready, rsp_valid, rsp_data, ld_err, init_done
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
      output req_ready, rsp_valid, rsp_data, ld_err, init_done
   );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: fills the array after reset (INIT), then serves
// 1-cycle-latency fetches with a valid/ready response and accepts program loads.
// Define IMEM_DEFAULT_PROG_EN to fill a small boot program instead of all NOPs
// (that build requires DATA_W = 32).
module instr_mem_ctrl #(
   parameter int unsigned       ADDR_W   = 8,
   parameter int unsigned       DEPTH    = 256,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h20000000)
) (
   input logic              clk,
   input logic              rst_n,
   instr_mem_ctrl_if.slave  bus
);

   typedef enum logic [0:0] {StInit, StRun} state_e;

   localparam logic [ADDR_W:0]   DepthCmp = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              ld_err_q, ld_err_d;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] fill_word;
   logic              accept;
   logic              req_in_range;
   logic              ld_in_range;

   assign req_in_range  = ({1'b0, bus.req_addr} < DepthCmp);
   assign ld_in_range   = ({1'b0, bus.ld_addr} < DepthCmp);
   assign bus.init_done = (state_q == StRun);
   assign bus.req_ready = bus.init_done && (!rsp_valid_q || bus.rsp_ready);
   assign accept        = bus.req_valid && bus.req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.ld_err    = ld_err_q;

   // Value written at the fill counter address during INIT.
   always_comb begin
      fill_word = NOP_WORD;
`ifdef IMEM_DEFAULT_PROG_EN
      case (int'(fill_cnt_q))
         0:       fill_word = DATA_W'(32'h20010003);
         1:       fill_word = DATA_W'(32'h20020009);
         2:       fill_word = DATA_W'(32'h00221020);
         3:       fill_word = DATA_W'(32'h00221824);
         4:       fill_word = DATA_W'(32'h00222025);
         5:       fill_word = DATA_W'(32'h20200002);
         default: fill_word = NOP_WORD;
      endcase
`endif
   end

   // Single write port: INIT fill owns it, otherwise an in-range load in RUN.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = fill_cnt_q;
      mem_wdata = fill_word;
      if (state_q == StInit) begin
         mem_we = 1'b1;
      end else if (bus.ld_en && ld_in_range) begin
         mem_we    = 1'b1;
         mem_waddr = bus.ld_addr;
         mem_wdata = bus.ld_data;
      end
   end

   // Storage array; not reset, INIT rewrites every word after each reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Next-state for FSM, fill counter, response register and load error pulse.
   always_comb begin
      state_d     = state_q;
      fill_cnt_d  = fill_cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      ld_err_d    = bus.ld_en && ((state_q == StInit) || !ld_in_range);

      if (state_q == StInit) begin
         fill_cnt_d = fill_cnt_q + 1'b1;
         if (fill_cnt_q == LastAddr) begin
            state_d    = StRun;
            fill_cnt_d = '0;
         end
      end

      // Read uses the pre-edge array contents, so a same-cycle load is not seen.
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = req_in_range ? mem[bus.req_addr] : NOP_WORD;
      end else if (bus.rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StInit;
         fill_cnt_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= NOP_WORD;
         ld_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_cnt_q  <= fill_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         ld_err_q    <= ld_err_d;
      end
   end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Testbench for instr_mem_ctrl: scoreboard on the default-depth instance, direct
// checks on a DEPTH=200 instance for out-of-range loads and fetches.
module tb_instr_mem_ctrl;

   localparam logic [31:0] Nop = 32'h20000000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   instr_mem_ctrl_if #(.ADDR_W(8), .DATA_W(32)) m ();
   instr_mem_ctrl_if #(.ADDR_W(8), .DATA_W(32)) m2 ();

   instr_mem_ctrl #(.ADDR_W(8), .DEPTH(256), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (m)
   );

   instr_mem_ctrl #(.ADDR_W(8), .DEPTH(200), .DATA_W(32)) dut200 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (m2)
   );

   int          n_chk = 0;
   int          n_pass = 0;
   logic [31:0] sb[$];
   logic [31:0] model [256];
   bit          run_phase = 1'b0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic init_model();
      for (int i = 0; i < 256; i++) model[i] = Nop;
`ifdef IMEM_DEFAULT_PROG_EN
      model[0] = 32'h20010003;
      model[1] = 32'h20020009;
      model[2] = 32'h00221020;
      model[3] = 32'h00221824;
      model[4] = 32'h00222025;
      model[5] = 32'h20200002;
`endif
   endtask

   // Scoreboard: pop/compare delivered responses, push expected on acceptance,
   // then apply loads to the model (read-before-write).
   always @(negedge clk) begin
      if (rst_n) begin
         if (m.rsp_valid && m.rsp_ready) begin
            if (sb.size() == 0) chk_eq("sb_underflow", 32'd1, 32'd0);
            else chk_eq("rsp_data", m.rsp_data, sb.pop_front());
         end
         if (m.req_valid && m.req_ready) sb.push_back(model[m.req_addr]);
         if (run_phase && m.ld_en) model[m.ld_addr] = m.ld_data;
      end
   end

   // Present one fetch on m and hold it until accepted (bounded).
   task automatic fetch(input logic [7:0] a);
      int n;
      n = 0;
      m.req_valid = 1'b1;
      m.req_addr  = a;
      @(negedge clk);
      while (!m.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!m.req_ready) chk_eq("fetch_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   // Single directly-checked fetch on the DEPTH=200 instance.
   task automatic fetch2(input logic [7:0] a, input logic [31:0] exp, input string tag);
      m2.req_valid = 1'b1;
      m2.req_addr  = a;
      @(negedge clk);
      chk_eq({tag, "_rdy"}, 32'(m2.req_ready), 32'd1);
      @(posedge clk);
      #1;
      m2.req_valid = 1'b0;
      @(negedge clk);
      chk_eq({tag, "_vld"}, 32'(m2.rsp_valid), 32'd1);
      chk_eq(tag, m2.rsp_data, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int t1;
      int t2;
      int c0;
      m.req_valid = 1'b0;  m.req_addr = '0;  m.rsp_ready = 1'b1;
      m.ld_en = 1'b0;      m.ld_addr = '0;   m.ld_data = '0;
      m2.req_valid = 1'b0; m2.req_addr = '0; m2.rsp_ready = 1'b1;
      m2.ld_en = 1'b0;     m2.ld_addr = '0;  m2.ld_data = '0;
      init_model();

      idle(3);
      chk_eq("rst_rsp_valid", 32'(m.rsp_valid), 32'd0);
      chk_eq("rst_rsp_data", m.rsp_data, Nop);
      chk_eq("rst_ld_err", 32'(m.ld_err), 32'd0);
      chk_eq("rst_init_done", 32'(m.init_done), 32'd0);
      chk_eq("rst_req_ready", 32'(m.req_ready), 32'd0);
      rst_n = 1'b1;

      // INIT length on both instances, with a rejected load early in INIT.
      t1 = 0;
      t2 = 0;
      for (int n = 1; n <= 300 && (t1 == 0 || t2 == 0); n++) begin
         @(posedge clk);
         #1;
         if (m.init_done && t1 == 0) t1 = n;
         if (m2.init_done && t2 == 0) t2 = n;
         if (n == 10) begin
            m.ld_en = 1'b1;  m.ld_addr = 8'h00;  m.ld_data = 32'hDEADBEEF;
            m2.ld_en = 1'b1; m2.ld_addr = 8'h05; m2.ld_data = 32'h11111111;
         end
         if (n == 11) begin
            chk_eq("init_ld_err", 32'(m.ld_err), 32'd1);
            chk_eq("init_ld_err_d200", 32'(m2.ld_err), 32'd1);
            m.ld_en = 1'b0;
            m2.ld_en = 1'b0;
         end
         if (n == 12) begin
            chk_eq("init_ld_err_end", 32'(m.ld_err), 32'd0);
            chk_eq("init_ld_err_end_d200", 32'(m2.ld_err), 32'd0);
         end
      end
      chk_eq("init_cycles", 32'(t1), 32'd256);
      chk_eq("init_cycles_d200", 32'(t2), 32'd200);
      run_phase = 1'b1;

      // Back-to-back fetch of 0..6 (address 0 must keep its fill value).
      c0 = cyc;
      for (int a = 0; a < 7; a++) fetch(8'(a));
      m.req_valid = 1'b0;
      chk_eq("stream_cycles", 32'(cyc - c0), 32'd7);
      idle(2);

      // Load, fetch it, then same-cycle fetch+load, then fetch the new word.
      m.ld_en = 1'b1; m.ld_addr = 8'h10; m.ld_data = 32'hDEADBEEF;
      idle(1);
      m.ld_en = 1'b0;
      chk_eq("ld_ok_no_err", 32'(m.ld_err), 32'd0);
      fetch(8'h10);
      m.ld_en = 1'b1; m.ld_addr = 8'h10; m.ld_data = 32'hCAFEF00D;
      fetch(8'h10);
      m.ld_en = 1'b0;
      fetch(8'h10);
      m.req_valid = 1'b0;
      idle(2);

      // Backpressure: response held stable, no acceptance while stalled.
      m.rsp_ready = 1'b0;
      fetch(8'h20);
      m.req_addr = 8'h30;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_eq("stall_req_ready", 32'(m.req_ready), 32'd0);
         chk_eq("stall_rsp_valid", 32'(m.rsp_valid), 32'd1);
         chk_eq("stall_rsp_data", m.rsp_data, Nop);
      end
      @(posedge clk);
      #1;
      m.rsp_ready = 1'b1;
      c0 = cyc;
      fetch(8'h10);
      fetch(8'h01);
      fetch(8'h02);
      m.req_valid = 1'b0;
      chk_eq("resume_cycles", 32'(cyc - c0), 32'd3);
      idle(2);

      // Out-of-range load and fetch on the DEPTH=200 instance.
      m2.ld_en = 1'b1; m2.ld_addr = 8'd200; m2.ld_data = 32'h12345678;
      idle(1);
      m2.ld_en = 1'b0;
      @(negedge clk);
      chk_eq("oor_ld_err", 32'(m2.ld_err), 32'd1);
      @(negedge clk);
      chk_eq("oor_ld_err_end", 32'(m2.ld_err), 32'd0);
      @(posedge clk);
      #1;
      fetch2(8'd200, Nop, "oor_fetch");
      fetch2(8'd199, Nop, "last_fetch");

      // Asynchronous reset mid-stream, then INIT reruns and refills.
      m.req_valid = 1'b1;
      m.req_addr  = 8'h01;
      @(posedge clk);
      #3;
      chk_eq("pre_rst_valid", 32'(m.rsp_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_eq("async_rsp_valid", 32'(m.rsp_valid), 32'd0);
      chk_eq("async_rsp_data", m.rsp_data, Nop);
      chk_eq("async_req_ready", 32'(m.req_ready), 32'd0);
      chk_eq("async_init_done", 32'(m.init_done), 32'd0);
      m.req_valid = 1'b0;
      sb.delete();
      run_phase = 1'b0;
      init_model();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      t1 = 0;
      for (int n = 1; n <= 300 && t1 == 0; n++) begin
         @(posedge clk);
         #1;
         if (m.init_done) t1 = n;
      end
      chk_eq("reinit_cycles", 32'(t1), 32'd256);
      run_phase = 1'b1;
      fetch(8'h10);
      fetch(8'h03);
      m.req_valid = 1'b0;
      idle(3);
      chk_eq("sb_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
